// File: rtl/astro_pkg.sv
// rtl/astro_pkg.sv - shared state encoding and result-plane constants for fetch_scheduler
package astro_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_TEM = 3'd1,
    FETCH_WIN = 3'd2,
    WAIT_NCC  = 3'd3,
    WR_IDX    = 3'd4,
    WR_HI     = 3'd5,
    WR_LO     = 3'd6,
    DONE      = 3'd7
  } state_t;

  // Result words land in the last row of the window/result plane
  localparam logic [6:0] RESULT_ROW    = 7'd127;
  localparam logic [6:0] RESULT_COL_IDX = 7'd0;
  localparam logic [6:0] RESULT_COL_HI  = 7'd1;
  localparam logic [6:0] RESULT_COL_LO  = 7'd2;

  // Selects one of the three result words: index, upper NCC half, lower NCC half
  function automatic logic [31:0] result_word(input logic [1:0] sel,
                                              input logic [8:0] idx,
                                              input logic [63:0] ncc);
    logic [31:0] w;
    case (sel)
      2'd0:    w = {23'b0, idx};
      2'd1:    w = ncc[63:32];
      default: w = ncc[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// rtl/raster_addr_gen.sv - square raster row/col counter with reload and last-address flag
module raster_addr_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] dim,
  input  logic       clear,
  input  logic       advance,
  output logic [6:0] row,
  output logic [6:0] col,
  output logic       last
);

  logic col_end;

  assign col_end = (col == dim - 7'd1);
  assign last    = col_end && (row == dim - 7'd1);

  // Column runs fastest; clear wins over advance so a plane switch reloads to 0,0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= 7'd0;
      col <= 7'd0;
    end else if (clear) begin
      row <= 7'd0;
      col <= 7'd0;
    end else if (advance) begin
      if (col_end) begin
        col <= 7'd0;
        row <= row + 7'd1;
      end else begin
        col <= col + 7'd1;
      end
    end
  end

endmodule

// File: rtl/fetch_scheduler.sv
// rtl/fetch_scheduler.sv - template/window fetch sequencer with optional result write-back (RESULT_WRITEBACK_EN)
module fetch_scheduler
  import astro_pkg::*;
#(
  parameter int TEM_DIM = 16,
  parameter int WIN_DIM = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ready_2_start,
  output logic        req,
  output logic        rd_wr,
  output logic [6:0]  row,
  output logic [6:0]  col,
  output logic        tem_win,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic        set_done,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  output logic        pix_is_tem,
  input  logic        dp_stall,
  input  logic        ncc_done,
  input  logic [63:0] greatestNCCLog2,
  input  logic [8:0]  greatestWindowIndex
);

  localparam logic [6:0] TEM_D = 7'(TEM_DIM);
  localparam logic [6:0] WIN_D = 7'(WIN_DIM);

  state_t     state, state_nxt;
  logic [6:0] gen_dim, gen_row, gen_col;
  logic       gen_clear, gen_advance, gen_last;

  assign gen_dim = (state == FETCH_WIN) ? WIN_D : TEM_D;

  raster_addr_gen u_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .dim     (gen_dim),
    .clear   (gen_clear),
    .advance (gen_advance),
    .row     (gen_row),
    .col     (gen_col),
    .last    (gen_last)
  );

`ifdef RESULT_WRITEBACK_EN
  logic [8:0]  cap_idx;
  logic [63:0] cap_ncc;

  // Latch the datapath result on the accepted ncc_done so later input changes do not leak into the writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_idx <= 9'd0;
      cap_ncc <= 64'd0;
    end else if (state == WAIT_NCC && ncc_done) begin
      cap_idx <= greatestWindowIndex;
      cap_ncc <= greatestNCCLog2;
    end
  end
`else
  logic unused_result;
  assign unused_result = ^{greatestNCCLog2, greatestWindowIndex};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, memory request and address/data outputs
  always_comb begin
    state_nxt   = state;
    req         = 1'b0;
    rd_wr       = 1'b0;
    tem_win     = 1'b0;
    row         = 7'd0;
    col         = 7'd0;
    write_data  = 32'd0;
    set_done    = 1'b0;
    gen_clear   = 1'b0;
    gen_advance = 1'b0;
    case (state)
      IDLE: begin
        if (ready_2_start) begin
          state_nxt = FETCH_TEM;
          gen_clear = 1'b1;
        end
      end
      FETCH_TEM: begin
        tem_win = 1'b1;
        row     = gen_row;
        col     = gen_col;
        if (!dp_stall) begin
          req         = 1'b1;
          gen_advance = 1'b1;
          if (gen_last) begin
            state_nxt = FETCH_WIN;
            gen_clear = 1'b1;
          end
        end
      end
      FETCH_WIN: begin
        row = gen_row;
        col = gen_col;
        if (!dp_stall) begin
          req         = 1'b1;
          gen_advance = 1'b1;
          if (gen_last) begin
            state_nxt = WAIT_NCC;
            gen_clear = 1'b1;
          end
        end
      end
      WAIT_NCC: begin
`ifdef RESULT_WRITEBACK_EN
        if (ncc_done) state_nxt = WR_IDX;
`else
        if (ncc_done) state_nxt = DONE;
`endif
      end
`ifdef RESULT_WRITEBACK_EN
      WR_IDX: begin
        req        = 1'b1;
        rd_wr      = 1'b1;
        row        = RESULT_ROW;
        col        = RESULT_COL_IDX;
        write_data = result_word(2'd0, cap_idx, cap_ncc);
        state_nxt  = WR_HI;
      end
      WR_HI: begin
        req        = 1'b1;
        rd_wr      = 1'b1;
        row        = RESULT_ROW;
        col        = RESULT_COL_HI;
        write_data = result_word(2'd1, cap_idx, cap_ncc);
        state_nxt  = WR_LO;
      end
      WR_LO: begin
        req        = 1'b1;
        rd_wr      = 1'b1;
        row        = RESULT_ROW;
        col        = RESULT_COL_LO;
        write_data = result_word(2'd2, cap_idx, cap_ncc);
        state_nxt  = DONE;
      end
`endif
      DONE: begin
        set_done = 1'b1;
        if (!ready_2_start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data arrives one cycle after the request; remember which plane it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid  <= 1'b0;
      pix_is_tem <= 1'b0;
    end else begin
      pix_valid  <= req && !rd_wr;
      pix_is_tem <= req && !rd_wr && tem_win;
    end
  end

  assign pix_data = pix_valid ? read_data : 32'd0;

endmodule
